// File: rtl/reg_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_arb_pkg
// Brief    : Shared FSM type, ID-width helper and default timing constants
//            for the register-bank access arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package reg_arb_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WRITE      = 3'd1,
    READ_ISSUE = 3'd2,
    READ_WAIT  = 3'd3,
    DONE       = 3'd4
  } arb_state_t;

  localparam int c_DEF_ACK_TIMEOUT  = 255;
  localparam int c_DEF_READ_LATENCY = 2;

  function automatic int idWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : rr_picker
// Brief    : Combinational round-robin search; first set request bit after ptr.
// Revision : 1.0 - initial release
// ============================================================================
module rr_picker
  import reg_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = idWidth(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic               grantValid,
  output logic [IDW-1:0]     grantIdx
);

  logic [IDW-1:0] w_idx;

  // Scan farthest-to-nearest so the nearest set bit after ptr is written last.
  always_comb begin
    grantValid = 1'b0;
    grantIdx   = '0;
    w_idx      = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_idx = IDW'((int'(ptr) + k) % NUM_REQ);
      if (req[w_idx]) begin
        grantValid = 1'b1;
        grantIdx   = w_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/reg_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_access_arbiter
// Brief    : Round-robin sharing of the single register-bank port among
//            NUM_REQ requesters, with write-ack timeout reporting.
// Revision : 1.0 - initial release
// ============================================================================
module reg_access_arbiter
  import reg_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int ADDRWIDTH    = 8,
  parameter int DATA_LENGTH  = 32,
  parameter int READ_LATENCY = c_DEF_READ_LATENCY,
  parameter int ACK_TIMEOUT  = c_DEF_ACK_TIMEOUT
) (
  input  logic                             clk,
  input  logic                             rsnt,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_write,
  input  logic [NUM_REQ-1:0]               req_admin,
  input  logic [NUM_REQ*ADDRWIDTH-1:0]     req_addr,
  input  logic [NUM_REQ*DATA_LENGTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]               req_ack,
  output logic                             req_err,
  output logic [DATA_LENGTH-1:0]           req_rdata,
  output logic [ADDRWIDTH-1:0]             address,
  output logic [DATA_LENGTH-1:0]           writeData,
  output logic                             writeEnable,
  output logic                             readEnable,
  output logic                             writeAdmin,
  input  logic                             writeAck,
  input  logic [DATA_LENGTH-1:0]           readData,
  output logic                             busy,
  output logic [idWidth(NUM_REQ)-1:0]      grant_id
);

  localparam int c_IDW     = idWidth(NUM_REQ);
  localparam int c_CNT_MAX = (ACK_TIMEOUT > READ_LATENCY) ? ACK_TIMEOUT : READ_LATENCY;
  localparam int c_CW      = $clog2(c_CNT_MAX + 1);

  arb_state_t         r_state;
  logic [c_IDW-1:0]   r_ptr;
  logic [c_CW-1:0]    r_cnt;
  logic               w_grantValid;
  logic [c_IDW-1:0]   w_grantIdx;
  logic [NUM_REQ-1:0] w_ackVec;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDW     (c_IDW)
  ) u_rr_picker (
    .req        (req_valid),
    .ptr        (r_ptr),
    .grantValid (w_grantValid),
    .grantIdx   (w_grantIdx)
  );

  assign w_ackVec = NUM_REQ'(1) << grant_id;
  assign busy     = (r_state != IDLE);

  always_ff @(posedge clk) begin
    if (rsnt) begin
      r_state     <= IDLE;
      r_ptr       <= c_IDW'(NUM_REQ - 1);
      r_cnt       <= '0;
      req_ack     <= '0;
      req_err     <= 1'b0;
      req_rdata   <= '0;
      address     <= '0;
      writeData   <= '0;
      writeEnable <= 1'b0;
      readEnable  <= 1'b0;
      writeAdmin  <= 1'b0;
      grant_id    <= '0;
    end else begin
      req_ack    <= '0;
      req_err    <= 1'b0;
      readEnable <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grantValid) begin
            r_ptr     <= w_grantIdx;
            grant_id  <= w_grantIdx;
            address   <= req_addr[int'(w_grantIdx)*ADDRWIDTH +: ADDRWIDTH];
            writeData <= req_wdata[int'(w_grantIdx)*DATA_LENGTH +: DATA_LENGTH];
            if (req_write[w_grantIdx]) begin
              writeEnable <= 1'b1;
              writeAdmin  <= req_admin[w_grantIdx];
              r_cnt       <= c_CW'(1);
              r_state     <= WRITE;
            end else begin
              readEnable <= 1'b1;
              r_state    <= READ_ISSUE;
            end
          end
        end
        WRITE: begin
          // An ack on the expiry cycle is checked first and so beats the timeout.
          if (writeAck) begin
            writeEnable <= 1'b0;
            writeAdmin  <= 1'b0;
            req_ack     <= w_ackVec;
            r_state     <= DONE;
          end else if (r_cnt == c_CW'(ACK_TIMEOUT)) begin
            writeEnable <= 1'b0;
            writeAdmin  <= 1'b0;
            req_ack     <= w_ackVec;
            req_err     <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_cnt <= r_cnt + c_CW'(1);
          end
        end
        READ_ISSUE: begin
          r_cnt   <= c_CW'(1);
          r_state <= READ_WAIT;
        end
        READ_WAIT: begin
          if (r_cnt == c_CW'(READ_LATENCY)) begin
            req_rdata <= readData;
            req_ack   <= w_ackVec;
            r_state   <= DONE;
          end else begin
            r_cnt <= r_cnt + c_CW'(1);
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/reg_access_arbiter.md
Name: reg_access_arbiter

Overview:
Shares the single register-bank access port (address/writeData/writeEnable/readEnable/writeAdmin/writeAck/readData) among NUM_REQ requesters: command manager, TDC channel-enable reader, sync error-flag writer and spares.
- Each requester gets a uniform request/ack handshake.
- Arbitration is round-robin; the bank is sequenced one transaction at a time.
- Write-ack timeouts are reported instead of hanging.
- Sits between the requesting managers and the registers block.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDRWIDTH, 8, register address width
DATA_LENGTH, 32, register data width
READ_LATENCY, 2, cycles from readEnable high to readData valid (>=1)
ACK_TIMEOUT, 255, max cycles writeEnable is held waiting for writeAck (>=1)

Ports:
clk  in  1  system clock
rsnt  in  1  synchronous reset, active-high
req_valid  in  NUM_REQ  request pending; held until req_ack
req_write  in  NUM_REQ  1=write, 0=read
req_admin  in  NUM_REQ  admin write (drives writeAdmin)
req_addr  in  NUM_REQ*ADDRWIDTH  packed addresses; requester i at [i*ADDRWIDTH +: ADDRWIDTH]
req_wdata  in  NUM_REQ*DATA_LENGTH  packed write data
req_ack  out  NUM_REQ  one-cycle completion pulse, one-hot
req_err  out  1  valid with req_ack; 1 = write timed out
req_rdata  out  DATA_LENGTH  read data; valid with req_ack for a read
address  out  ADDRWIDTH  to bank
writeData  out  DATA_LENGTH  to bank
writeEnable  out  1  to bank; level, held until writeAck or timeout
readEnable  out  1  to bank; one-cycle strobe
writeAdmin  out  1  to bank; equals writeEnable AND latched admin bit
writeAck  in  1  from bank
readData  in  DATA_LENGTH  from bank
busy  out  1  transaction in progress (state != IDLE)
grant_id  out  $clog2(NUM_REQ)  index of current/last grantee

Behaviour:
- Reset: all outputs 0; rr pointer = NUM_REQ-1, so requester 0 wins first; any in-flight transaction is dropped with no ack; counters cleared; state IDLE.
- Reset mid-write: writeEnable falls the cycle after rsnt is sampled.
- Handshake:
  - Requester raises req_valid with stable write/admin/addr/wdata fields.
  - Arbiter latches the fields at grant; later changes are ignored.
  - req_ack pulses exactly 1 cycle.
  - Requester must drop req_valid the cycle after req_ack; otherwise it is treated as a new request.
  - Dropping req_valid before ack is illegal; the transaction still completes and acks.
- Arbitration:
  - In IDLE, if any req_valid is high, grant the first set bit searching from pointer+1 modulo NUM_REQ.
  - Pointer updates to the grantee on grant only.
  - No new grant until DONE has elapsed, so there is no back-to-back overlap.
- FSM:
  - IDLE: on grant, latch fields and grant_id; go to WRITE if write, else READ_ISSUE.
  - WRITE:
    - address/writeData driven from the latch; writeEnable=1; writeAdmin=admin.
    - Timeout counter increments each cycle.
    - If writeAck: deassert next cycle, err=0, go to DONE.
    - Else if count==ACK_TIMEOUT: deassert, err=1, go to DONE.
    - writeAck in the same cycle as expiry: ack wins, err=0.
  - READ_ISSUE: readEnable=1 for exactly this cycle; counter=1; go to READ_WAIT.
  - READ_WAIT: when counter==READ_LATENCY, capture readData into req_rdata and go to DONE; else increment.
  - DONE: req_ack[grant_id]=1 and req_err valid for one cycle; go to IDLE.
- Latency:
  - Read: request seen at cycle N → readEnable at N+1 → capture at N+1+READ_LATENCY → req_ack at N+2+READ_LATENCY.
  - Write with immediate ack: writeEnable at N+1; writeAck at N+1 → req_ack at N+2.
- Output hold:
  - address holds its last value in IDLE.
  - req_rdata holds until the next read capture.
  - req_err is cleared when not in DONE.
- writeAck outside WRITE is ignored.

Decomposition:
- Package reg_arb_pkg holds:
  - arb_state_t enum {IDLE, WRITE, READ_ISSUE, READ_WAIT, DONE};
  - the ID-width localparam helper;
  - default timeout/latency constants.
- Sub-module rr_picker: combinational round-robin search taking req vector and pointer, returning grant_valid and grant_idx. It is instantiated once and tested standalone.

Test Plan:
- Single read: req_valid[1]=1, addr 0x08, bank returns 0xA5A5_0003 two cycles after readEnable → readEnable pulses once at N+1; req_ack[1] at N+4; req_rdata=0xA5A5_0003; req_err=0.
- Write with ack: req 2 writes 0x0000_0001 to 0x05 with admin=1; writeAck 3 cycles later → writeEnable=writeAdmin=1 for 3 cycles, address=0x05; req_ack[2] one cycle after writeAck; err=0.
- Fairness: all 4 requesters hold req_valid continuously → grant order after reset 0,1,2,3,0; no requester is acked twice before the others are acked once.
- Timeout: ACK_TIMEOUT=10, writeAck never asserted → writeEnable high for 10 cycles then low; req_ack with req_err=1. Repeat with writeAck on exactly the expiry cycle → req_err=0.
- Reset mid-operation: assert rsnt during READ_WAIT → no req_ack; all outputs 0 the next cycle; a subsequent request from requester 3 alone is granted normally.
- Protocol: requester drops req_valid during WRITE → transaction completes and acks. Requester holds req_valid after ack → treated as a second request, granted after other pending requesters per rotation.
